// File: rtl/reg_mask_pkg.sv
// Shared constants, FSM state type and helpers for the register-mask sequencer.
// Used by the default build and by the REG_MASK_SEQ_DESCEND_EN build.
package reg_mask_pkg;

  localparam int N_REGS = 32;
  localparam int IDX_W  = 5;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  // True when exactly one bit of v is set (clearing the lowest set bit leaves zero).
  function automatic logic is_single(input logic [N_REGS-1:0] v);
    return (v != '0) && ((v & (v - N_REGS'(1))) == '0);
  endfunction

endpackage

// File: rtl/reg_mask_sequencer_prio_enc32.sv
// Combinational 32-to-5 lowest-set-bit priority encoder with an any-set flag.
module prio_enc32
  import reg_mask_pkg::*;
(
  input  logic [N_REGS-1:0] i_vec,
  output logic [IDX_W-1:0]  o_idx,
  output logic              o_any
);

  // Scanning from the top down leaves the lowest set bit as the final winner.
  always_comb begin
    o_idx = '0;
    for (int i = N_REGS - 1; i >= 0; i--) begin
      if (i_vec[i]) o_idx = IDX_W'(i);
    end
  end

  assign o_any = |i_vec;

endmodule

// File: rtl/reg_mask_sequencer.sv
// Drains a multi-hot register mask as one register index per cycle over valid/ready.
// Define REG_MASK_SEQ_DESCEND_EN to emit highest register first instead of lowest.
module reg_mask_sequencer
  import reg_mask_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N_REGS-1:0] in_mask,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [IDX_W-1:0]  out_idx,
  output logic              out_last,
  output logic              done,
  output state_t            dbg_state
);

  // Handshake: a transfer happens on a rising edge where valid & ready are both high;
  // the producer holds its payload stable while valid is high and ready is low.

  state_t             r_state, w_next_state;
  logic [N_REGS-1:0]  r_pending, w_next_pending;
  logic               r_done, w_next_done;
  logic [N_REGS-1:0]  w_enc_in;
  logic [IDX_W-1:0]   w_enc_idx;
  logic [IDX_W-1:0]   w_idx;
  logic               w_any;
  logic               w_accept;
  logic               w_hs;

`ifdef REG_MASK_SEQ_DESCEND_EN
  // Highest set bit of pending is the lowest set bit of the reversed vector.
  assign w_enc_in = {<<{r_pending}};
  assign w_idx    = ~w_enc_idx;
`else
  assign w_enc_in = r_pending;
  assign w_idx    = w_enc_idx;
`endif

  prio_enc32 u_prio_enc32 (
    .i_vec (w_enc_in),
    .o_idx (w_enc_idx),
    .o_any (w_any)
  );

  assign in_ready  = (r_state == IDLE) && !reset;
  assign out_valid = (r_state == EMIT) && w_any;
  assign out_idx   = out_valid ? w_idx : '0;
  assign out_last  = out_valid && is_single(r_pending);
  assign done      = r_done;
  assign dbg_state = r_state;

  assign w_accept = in_valid && in_ready;
  assign w_hs     = out_valid && out_ready;

  always_comb begin
    w_next_state   = r_state;
    w_next_pending = r_pending;
    w_next_done    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (in_mask != '0) begin
            w_next_pending = in_mask;
            w_next_state   = EMIT;
          end else begin
            w_next_done = 1'b1;
          end
        end
      end
      EMIT: begin
        if (w_hs) begin
          w_next_pending = r_pending & ~(N_REGS'(1) << w_idx);
          if (out_last) begin
            w_next_state = IDLE;
            w_next_done  = 1'b1;
          end
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= IDLE;
      r_pending <= '0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_next_state;
      r_pending <= w_next_pending;
      r_done    <= w_next_done;
    end
  end

endmodule

// File: doc/reg_mask_sequencer.md
Name: reg_mask_sequencer

Overview:
- Inverse of the 5-to-32 register-select decode.
- Accepts a 32-bit multi-hot register mask, e.g. a load/store-pair or register-list operand.
- Emits one 5-bit register number per cycle, ascending, over a valid/ready handshake.
- Sits between instruction decode and the register-file read/write-port sequencing logic.

Parameters:
- N_REGS, 32, width of the register mask (number of architectural registers)
- IDX_W, 5, width of the emitted register index; must equal clog2(N_REGS)

Ports:
- clock  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  in_mask is valid
- in_ready  out  1  block can accept a new mask
- in_mask  in  N_REGS  register mask; bit k set = register k requested
- out_valid  out  1  out_idx holds a valid register number
- out_ready  in  1  consumer accepts out_idx
- out_idx  out  IDX_W  register number being emitted
- out_last  out  1  out_idx is the final register of the current mask
- done  out  1  one-cycle pulse when a mask has been fully drained

Behaviour:
- Clock and reset: one clock, `clock`. Reset `reset` is synchronous and active-high.
- Reset values (registered outputs):
  - state=IDLE, pending=0, out_valid=0, out_idx=0, out_last=0, done=0.
  - in_ready=0 while reset is high; in_ready=1 in the first cycle after reset deasserts.
- States:
  - IDLE: in_ready=1, out_valid=0.
  - EMIT: in_ready=0, out_valid=1.
- Input accept happens when in_valid & in_ready:
  - Nonzero mask: pending<=in_mask; state->EMIT.
  - Zero mask: dropped; state stays IDLE; done=1 next cycle. No output beat.
- Latency: the first out_valid is asserted 1 cycle after accept. There is no same-cycle bypass.
- In EMIT:
  - out_idx = index of the lowest set bit of pending.
  - out_last = 1 iff pending has exactly one bit set.
- Output handshake happens when out_valid & out_ready:
  - Clear the emitted bit in pending.
  - If out_last: state->IDLE, done=1 next cycle.
  - Otherwise, the next index is presented the following cycle.
  - Throughput is 1 index/cycle while out_ready stays high.
- Backpressure: out_idx and out_last hold stable while out_valid & ~out_ready.
- New masks are never accepted in EMIT. The earliest new accept is the cycle after the last handshake, which is also the cycle done is high.
- Full mask 0xFFFFFFFF: emits 0..31, 32 beats; out_last on 31.
- Single bit: one beat with out_last=1 on the first beat.
- Reset mid-operation discards pending. No done pulse; outputs return to reset values.
- in_mask is sampled only on accept; later changes are ignored.

Optional Feature:
- Macro: REG_MASK_SEQ_DESCEND_EN.
- Defined: emission order is descending (highest set bit first); out_last marks the lowest register.
- Undefined: ascending order as specified above.
- Handshake, latency and done timing are identical in both builds.

Decomposition:
- Shared package reg_mask_pkg holds:
  - constants N_REGS=32 and IDX_W=5;
  - the state enum {IDLE, EMIT};
  - a popcount-is-one helper function.
- One natural sub-module: prio_enc32, a combinational 32-to-5 lowest-set-bit encoder with an any-set flag.
  - In the descend build, prio_enc32 is fed the bit-reversed mask and its index is inverted.

Test Plan:
- Reset, then in_mask=0x0000_0005 with out_ready=1 -> out_idx 0 then 2; out_last on 2; done the cycle after; in_ready=1 that same cycle.
- in_mask=0x8000_0001, out_ready low 3 cycles on the first beat -> out_idx=0 held stable for 3 cycles, then 31 with out_last=1.
- in_mask=0xFFFF_FFFF, out_ready=1 -> 32 consecutive beats 0..31; out_last only on 31; in_ready=0 throughout.
- in_mask=0 accepted -> no out_valid; done pulses 1 cycle later; state stays IDLE.
- in_mask=0x0000_00F0, assert reset after 2 beats (4, 5) -> outputs zero next cycle; no done; a new mask 0x2 then emits only 1.
- Descend build, in_mask=0x0000_0005 -> out_idx 2 then 0; out_last on 0.
